vmem_arbiter: RTL and testbench
===============================

Name: vmem_arbiter

Overview:
- Arbitrates instruction-fetch and data requests, issued with virtual addresses, onto a single physical memory bus.
- For the granted request it performs fixed-segment MIPS address translation (kseg0/kseg1 unmapping, uncached flag), registers the request and holds it until the memory responds.
- Routes the response back to the requester that owns the transaction.
- Sits between the CPU core's fetch/memory stages and the cache/bus interconnect.

Parameters:
- DATA_PRIO, 1: 1 = data port always wins ties; 0 = round-robin between ports on ties.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ireq_valid  in  1  instruction read request; held until ireq_ok.
- ireq_vaddr  in  32  instruction virtual address.
- ireq_ok  out  1  one-cycle response strobe for the instruction port.
- ireq_rdata  out  32  instruction read data; valid while ireq_ok=1.
- dreq_valid  in  1  data request; held until dreq_ok.
- dreq_vaddr  in  32  data virtual address.
- dreq_write  in  1  1 = store, 0 = load.
- dreq_size  in  2  0=byte, 1=half, 2=word.
- dreq_strobe  in  4  byte enables for stores.
- dreq_wdata  in  32  store data.
- dreq_ok  out  1  one-cycle response strobe for the data port.
- dreq_rdata  out  32  load data; valid while dreq_ok=1.
- mreq_valid  out  1  memory request valid.
- mreq_paddr  out  32  translated physical address.
- mreq_uncached  out  1  1 when the source vaddr[31:28] is 0xA or 0xB.
- mreq_write  out  1  store flag.
- mreq_size  out  2  access size.
- mreq_strobe  out  4  byte enables.
- mreq_wdata  out  32  store data.
- mresp_ok  in  1  memory completion strobe.
- mresp_rdata  in  32  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D.
- Reset values: state=IDLE, all mreq_* outputs 0, busy=0, last_grant=INSTR.
  - Reset is asynchronous. Asserting it mid-transaction drops mreq_valid immediately and discards the transaction; no ok strobe is produced.
- Translation:
  - paddr[27:0] = vaddr[27:0].
  - vaddr[31:28] of 0x8 or 0xA -> paddr[31:28]=0x0.
  - vaddr[31:28] of 0x9 or 0xB -> paddr[31:28]=0x1.
  - Any other value passes through unchanged.
  - uncached = (vaddr[31:28] is 0xA or 0xB).
- IDLE: if any *_valid is high, select a winner and register its translated request into the mreq_* registers. Move to BUSY_I or BUSY_D on the next edge.
  - Instruction requests register as write=0, size=2, strobe=0, wdata=0.
- Arbitration on tie:
  - DATA_PRIO=1: data port wins.
  - DATA_PRIO=0: winner is the port opposite last_grant, and last_grant updates on every grant. Since last_grant resets to INSTR, the first tie after reset goes to data.
- BUSY_x: mreq_valid=1 with all mreq_* fields stable until mresp_ok.
  - On a mresp_ok cycle, the owning port's *_ok=1 and *_rdata=mresp_rdata, combinationally in the same cycle.
  - On that edge, mreq_valid clears and state returns to IDLE.
- Latency: request seen at cycle 0 -> mreq_valid at cycle 1. mresp_ok at cycle k -> *_ok at cycle k. The next grant is earliest at cycle k+1 (IDLE), with mreq_valid at k+2.
- The non-owning *_ok is always 0. *_rdata is 0 whenever its ok is low.
- mresp_ok while IDLE is ignored.
- If the requester deasserts valid mid-transaction, the transaction still completes and ok still pulses.
- A requester still holding valid in the cycle after its ok is treated as a new request.
- The losing requester waits with valid held. Its request is not captured until the arbiter next sits in IDLE.

Test Plan:
- Single instruction read, ireq_vaddr=0xBFC00000, mresp_ok asserted 3 cycles after mreq_valid → mreq_paddr=0x1FC00000, mreq_uncached=1, mreq_write=0, mreq_size=2. ireq_ok pulses one cycle carrying mresp_rdata; dreq_ok stays 0.
- Data store, dreq_vaddr=0x80001234, size=2, strobe=0xF, wdata=0xDEADBEEF → mreq_paddr=0x00001234, uncached=0, write=1. All mreq_* fields stay stable until mresp_ok, then dreq_ok pulses.
- Both ports valid at the same cycle with DATA_PRIO=1 → data is served first and instruction second. Each ok pulses once, in order, and busy drops only between the two transactions.
- DATA_PRIO=0, both ports held valid continuously for 4 transactions → grant order D, I, D, I.
- Passthrough address dreq_vaddr=0x1FC00010 → mreq_paddr=0x1FC00010, uncached=0. Separately, vaddr=0xC0000000 → paddr=0xC0000000.
- resetn pulled low while in BUSY_D → mreq_valid=0 and busy=0 immediately, no dreq_ok. After release, a held dreq_valid is granted afresh with mreq_valid one cycle later.

Source files
------------

// File: rtl/vmem_arbiter.sv
`default_nettype none
// vmem_arbiter: arbitrates instruction-fetch and data virtual-address requests onto a single
// physical memory bus with fixed-segment MIPS translation. Rev 1.0
module vmem_arbiter #(
  parameter int DATA_PRIO = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ireq_valid,
  input  logic [31:0] ireq_vaddr,
  output logic        ireq_ok,
  output logic [31:0] ireq_rdata,
  input  logic        dreq_valid,
  input  logic [31:0] dreq_vaddr,
  input  logic        dreq_write,
  input  logic [1:0]  dreq_size,
  input  logic [3:0]  dreq_strobe,
  input  logic [31:0] dreq_wdata,
  output logic        dreq_ok,
  output logic [31:0] dreq_rdata,
  output logic        mreq_valid,
  output logic [31:0] mreq_paddr,
  output logic        mreq_uncached,
  output logic        mreq_write,
  output logic [1:0]  mreq_size,
  output logic [3:0]  mreq_strobe,
  output logic [31:0] mreq_wdata,
  input  logic        mresp_ok,
  input  logic [31:0] mresp_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        mreq_valid_q, mreq_valid_d;
  logic [31:0] mreq_paddr_q, mreq_paddr_d;
  logic        mreq_uncached_q, mreq_uncached_d;
  logic        mreq_write_q, mreq_write_d;
  logic [1:0]  mreq_size_q, mreq_size_d;
  logic [3:0]  mreq_strobe_q, mreq_strobe_d;
  logic [31:0] mreq_wdata_q, mreq_wdata_d;

  logic        data_wins;
  logic [31:0] sel_vaddr;
  logic [3:0]  seg;
  logic [3:0]  phys_seg;

  // Data wins when it is the only requester, or on a tie by priority / round-robin.
  always_comb begin
    data_wins = dreq_valid &&
                (!ireq_valid || (DATA_PRIO != 0) || (last_grant_q == GRANT_I));
    sel_vaddr = data_wins ? dreq_vaddr : ireq_vaddr;
    seg       = sel_vaddr[31:28];
    unique case (seg)
      4'h8, 4'hA: phys_seg = 4'h0;
      4'h9, 4'hB: phys_seg = 4'h1;
      default:    phys_seg = seg;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    mreq_valid_d    = mreq_valid_q;
    mreq_paddr_d    = mreq_paddr_q;
    mreq_uncached_d = mreq_uncached_q;
    mreq_write_d    = mreq_write_q;
    mreq_size_d     = mreq_size_q;
    mreq_strobe_d   = mreq_strobe_q;
    mreq_wdata_d    = mreq_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (ireq_valid || dreq_valid) begin
          if (data_wins) begin
            state_d      = BUSY_D;
            last_grant_d = GRANT_D;
          end else begin
            state_d      = BUSY_I;
            last_grant_d = GRANT_I;
          end
          mreq_valid_d    = 1'b1;
          mreq_paddr_d    = {phys_seg, sel_vaddr[27:0]};
          mreq_uncached_d = (seg == 4'hA) || (seg == 4'hB);
          mreq_write_d    = data_wins ? dreq_write : 1'b0;
          mreq_size_d     = data_wins ? dreq_size : 2'd2;
          mreq_strobe_d   = data_wins ? dreq_strobe : 4'h0;
          mreq_wdata_d    = data_wins ? dreq_wdata : 32'h0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mresp_ok) begin
          state_d      = IDLE;
          mreq_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= IDLE;
      last_grant_q    <= GRANT_I;
      mreq_valid_q    <= 1'b0;
      mreq_paddr_q    <= 32'h0;
      mreq_uncached_q <= 1'b0;
      mreq_write_q    <= 1'b0;
      mreq_size_q     <= 2'd0;
      mreq_strobe_q   <= 4'h0;
      mreq_wdata_q    <= 32'h0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      mreq_valid_q    <= mreq_valid_d;
      mreq_paddr_q    <= mreq_paddr_d;
      mreq_uncached_q <= mreq_uncached_d;
      mreq_write_q    <= mreq_write_d;
      mreq_size_q     <= mreq_size_d;
      mreq_strobe_q   <= mreq_strobe_d;
      mreq_wdata_q    <= mreq_wdata_d;
    end
  end

  // Response routing is combinational so the requester sees ok in the mresp_ok cycle.
  assign ireq_ok       = (state_q == BUSY_I) && mresp_ok;
  assign dreq_ok       = (state_q == BUSY_D) && mresp_ok;
  assign ireq_rdata    = ireq_ok ? mresp_rdata : 32'h0;
  assign dreq_rdata    = dreq_ok ? mresp_rdata : 32'h0;
  assign busy          = (state_q != IDLE);
  assign mreq_valid    = mreq_valid_q;
  assign mreq_paddr    = mreq_paddr_q;
  assign mreq_uncached = mreq_uncached_q;
  assign mreq_write    = mreq_write_q;
  assign mreq_size     = mreq_size_q;
  assign mreq_strobe   = mreq_strobe_q;
  assign mreq_wdata    = mreq_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_vmem_arbiter.sv
`default_nettype none
// tb_vmem_arbiter: directed literal checks plus randomized traffic against a transaction-level
// model, for a DATA_PRIO=1 instance (u_dp) and a round-robin instance (u_rr). Rev 1.0
module tb_vmem_arbiter;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // Index 0 drives u_dp (DATA_PRIO=1), index 1 drives u_rr (DATA_PRIO=0).
  logic        iv [2];
  logic [31:0] ia [2];
  logic        iok[2];
  logic [31:0] ir [2];
  logic        dv [2];
  logic [31:0] da [2];
  logic        dw [2];
  logic [1:0]  dsz[2];
  logic [3:0]  dst[2];
  logic [31:0] dwd[2];
  logic        dok[2];
  logic [31:0] dr [2];
  logic        mv [2];
  logic [31:0] mpa[2];
  logic        munc[2];
  logic        mwr[2];
  logic [1:0]  msz[2];
  logic [3:0]  mst[2];
  logic [31:0] mwd[2];
  logic        mok[2];
  logic [31:0] mrd[2];
  logic        bsy[2];

  vmem_arbiter #(.DATA_PRIO(1)) u_dp (
    .clk(clk), .resetn(resetn),
    .ireq_valid(iv[0]), .ireq_vaddr(ia[0]), .ireq_ok(iok[0]), .ireq_rdata(ir[0]),
    .dreq_valid(dv[0]), .dreq_vaddr(da[0]), .dreq_write(dw[0]), .dreq_size(dsz[0]),
    .dreq_strobe(dst[0]), .dreq_wdata(dwd[0]), .dreq_ok(dok[0]), .dreq_rdata(dr[0]),
    .mreq_valid(mv[0]), .mreq_paddr(mpa[0]), .mreq_uncached(munc[0]), .mreq_write(mwr[0]),
    .mreq_size(msz[0]), .mreq_strobe(mst[0]), .mreq_wdata(mwd[0]),
    .mresp_ok(mok[0]), .mresp_rdata(mrd[0]), .busy(bsy[0])
  );

  vmem_arbiter #(.DATA_PRIO(0)) u_rr (
    .clk(clk), .resetn(resetn),
    .ireq_valid(iv[1]), .ireq_vaddr(ia[1]), .ireq_ok(iok[1]), .ireq_rdata(ir[1]),
    .dreq_valid(dv[1]), .dreq_vaddr(da[1]), .dreq_write(dw[1]), .dreq_size(dsz[1]),
    .dreq_strobe(dst[1]), .dreq_wdata(dwd[1]), .dreq_ok(dok[1]), .dreq_rdata(dr[1]),
    .mreq_valid(mv[1]), .mreq_paddr(mpa[1]), .mreq_uncached(munc[1]), .mreq_write(mwr[1]),
    .mreq_size(msz[1]), .mreq_strobe(mst[1]), .mreq_wdata(mwd[1]),
    .mresp_ok(mok[1]), .mresp_rdata(mrd[1]), .busy(bsy[1])
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[u%0d] @%0t: got %h, expected %h", nm, k, $time, act, exp);
  endtask

  // Waits (bounded) until the instance shows mreq_valid; ends at negedge+1.
  task automatic wait_mreq(input int k);
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (mv[k] !== 1'b1 && n < 20);
    chk("wait_mreq", k, mv[k], 1'b1);
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      iv[k] = 0; ia[k] = 0; dv[k] = 0; da[k] = 0; dw[k] = 0; dsz[k] = 0;
      dst[k] = 0; dwd[k] = 0; mok[k] = 0; mrd[k] = 0;
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_owner[2];   // 0 none, 1 instruction, 2 data
  logic        m_last [2];   // 0 instruction was last granted, 1 data
  logic        idone  [2];
  logic        ddone  [2];
  logic [31:0] m_pa   [2];
  logic        m_unc  [2];
  logic        m_wr   [2];
  logic [1:0]  m_sz   [2];
  logic [3:0]  m_st   [2];
  logic [31:0] m_wd   [2];

  function automatic logic [31:0] model_pa(input logic [31:0] va);
    int s;
    s = int'(va[31:28]);
    if (s >= 8 && s <= 11) return {4'(s % 2), va[27:0]};
    return va;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    return a;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = 0; m_last[k] = 0; idone[k] = 0; ddone[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    logic d;
    logic [31:0] va;
    if (m_owner[k] != 0) begin
      if (mok[k]) begin
        if (m_owner[k] == 1) idone[k] = 1; else ddone[k] = 1;
        m_owner[k] = 0;
      end
    end else if (iv[k] || dv[k]) begin
      d = dv[k] && (!iv[k] || k == 0 || m_last[k] == 0);
      m_owner[k] = d ? 2 : 1;
      m_last[k]  = d;
      va       = d ? da[k] : ia[k];
      m_pa[k]  = model_pa(va);
      m_unc[k] = (va[31:28] == 4'hA) || (va[31:28] == 4'hB);
      m_wr[k]  = d ? dw[k] : 1'b0;
      m_sz[k]  = d ? dsz[k] : 2'd2;
      m_st[k]  = d ? dst[k] : 4'h0;
      m_wd[k]  = d ? dwd[k] : 32'h0;
    end
  endtask

  task automatic model_compare(input int k);
    logic eb, ei, ed;
    eb = (m_owner[k] != 0);
    ei = (m_owner[k] == 1) && mok[k];
    ed = (m_owner[k] == 2) && mok[k];
    chk("busy", k, bsy[k], eb);
    chk("mreq_valid", k, mv[k], eb);
    if (eb) begin
      chk("mreq_paddr", k, mpa[k], m_pa[k]);
      chk("mreq_uncached", k, munc[k], m_unc[k]);
      chk("mreq_write", k, mwr[k], m_wr[k]);
      chk("mreq_size", k, msz[k], m_sz[k]);
      chk("mreq_strobe", k, mst[k], m_st[k]);
      chk("mreq_wdata", k, mwd[k], m_wd[k]);
    end
    chk("ireq_ok", k, iok[k], ei);
    chk("ireq_rdata", k, ir[k], ei ? mrd[k] : 32'h0);
    chk("dreq_ok", k, dok[k], ed);
    chk("dreq_rdata", k, dr[k], ed ? mrd[k] : 32'h0);
  endtask

  task automatic new_data(input int k);
    dv[k] = 1; da[k] = rand_addr(); dw[k] = $urandom_range(0, 1);
    dsz[k] = 2'($urandom_range(0, 2)); dst[k] = 4'($urandom); dwd[k] = $urandom;
  endtask

  task automatic drive_random(input int k);
    int r;
    if (m_owner[k] == 1) begin
      if (iv[k] && $urandom_range(0, 3) == 0) iv[k] = 0;
    end else if (idone[k]) begin
      idone[k] = 0;
      r = $urandom_range(0, 2);
      if (r == 0) iv[k] = 0;
      else if (r == 1) begin iv[k] = 1; ia[k] = rand_addr(); end
    end else if (!iv[k] && $urandom_range(0, 2) == 0) begin
      iv[k] = 1; ia[k] = rand_addr();
    end
    if (m_owner[k] == 2) begin
      if (dv[k] && $urandom_range(0, 3) == 0) dv[k] = 0;
    end else if (ddone[k]) begin
      ddone[k] = 0;
      r = $urandom_range(0, 2);
      if (r == 0) dv[k] = 0;
      else if (r == 1) new_data(k);
    end else if (!dv[k] && $urandom_range(0, 2) == 0) begin
      new_data(k);
    end
    mok[k] = ($urandom_range(0, 2) == 0);
    mrd[k] = $urandom;
  endtask

  initial begin
    clear_inputs();
    resetn = 0;
    @(negedge clk); @(negedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_mreq_valid", k, mv[k], 1'b0);
      chk("rst_busy", k, bsy[k], 1'b0);
      chk("rst_mreq_paddr", k, mpa[k], 32'h0);
      chk("rst_mreq_size", k, msz[k], 2'd0);
    end
    @(negedge clk); resetn = 1;

    // Single uncached instruction read, response 3 cycles after mreq_valid.
    @(negedge clk); iv[0] = 1; ia[0] = 32'hBFC0_0000; #1;
    chk("i_lat0_valid", 0, mv[0], 1'b0);
    @(negedge clk); #1;
    chk("i_valid", 0, mv[0], 1'b1);
    chk("i_paddr", 0, mpa[0], 32'h1FC0_0000);
    chk("i_uncached", 0, munc[0], 1'b1);
    chk("i_write", 0, mwr[0], 1'b0);
    chk("i_size", 0, msz[0], 2'd2);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      chk("i_wait_ok", 0, iok[0], 1'b0);
      chk("i_wait_valid", 0, mv[0], 1'b1);
    end
    @(negedge clk); mok[0] = 1; mrd[0] = 32'h1234_5678; #1;
    chk("i_ok", 0, iok[0], 1'b1);
    chk("i_rdata", 0, ir[0], 32'h1234_5678);
    chk("i_dok", 0, dok[0], 1'b0);
    @(negedge clk); iv[0] = 0; mok[0] = 0; #1;
    chk("i_ok_done", 0, iok[0], 1'b0);
    chk("i_idle", 0, bsy[0], 1'b0);

    // Cached data store with stable fields until the response.
    @(negedge clk); dv[0] = 1; da[0] = 32'h8000_1234; dw[0] = 1; dsz[0] = 2;
    dst[0] = 4'hF; dwd[0] = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("s_paddr", 0, mpa[0], 32'h0000_1234);
      chk("s_uncached", 0, munc[0], 1'b0);
      chk("s_write", 0, mwr[0], 1'b1);
      chk("s_strobe", 0, mst[0], 4'hF);
      chk("s_wdata", 0, mwd[0], 32'hDEAD_BEEF);
      chk("s_dok_wait", 0, dok[0], 1'b0);
    end
    @(negedge clk); mok[0] = 1; mrd[0] = 32'h0BAD_F00D; #1;
    chk("s_dok", 0, dok[0], 1'b1);
    chk("s_iok", 0, iok[0], 1'b0);
    @(negedge clk); dv[0] = 0; dw[0] = 0; mok[0] = 0;

    // Tie with data priority: data (passthrough address) first, instruction second.
    @(negedge clk); iv[0] = 1; ia[0] = 32'hBFC0_0000; dv[0] = 1; da[0] = 32'h1FC0_0010;
    dsz[0] = 2; dst[0] = 0; dwd[0] = 0;
    @(negedge clk); #1;
    chk("t_first_paddr", 0, mpa[0], 32'h1FC0_0010);
    chk("t_first_unc", 0, munc[0], 1'b0);
    @(negedge clk); mok[0] = 1; mrd[0] = 32'h0000_00D1; #1;
    chk("t_first_dok", 0, dok[0], 1'b1);
    chk("t_first_iok", 0, iok[0], 1'b0);
    @(negedge clk); dv[0] = 0; mok[0] = 0; #1;
    chk("t_gap_busy", 0, bsy[0], 1'b0);
    @(negedge clk); #1;
    chk("t_second_busy", 0, bsy[0], 1'b1);
    chk("t_second_paddr", 0, mpa[0], 32'h1FC0_0000);
    @(negedge clk); mok[0] = 1; mrd[0] = 32'h0000_00E2; #1;
    chk("t_second_iok", 0, iok[0], 1'b1);
    chk("t_second_dok", 0, dok[0], 1'b0);
    chk("t_second_rdata", 0, ir[0], 32'h0000_00E2);
    @(negedge clk); iv[0] = 0; mok[0] = 0; #1;
    chk("t_end_busy", 0, bsy[0], 1'b0);

    // Round-robin instance, both held valid: D, I, D, I.
    @(negedge clk); iv[1] = 1; ia[1] = 32'h0000_0100; dv[1] = 1; da[1] = 32'hC000_0000;
    dsz[1] = 2;
    for (int t = 0; t < 4; t++) begin
      logic exp_d;
      exp_d = (t % 2 == 0);
      wait_mreq(1);
      chk("rr_paddr", 1, mpa[1], exp_d ? 32'hC000_0000 : 32'h0000_0100);
      @(negedge clk); mok[1] = 1; mrd[1] = 32'hA5A5_0000 + 32'(t); #1;
      chk("rr_dok", 1, dok[1], exp_d);
      chk("rr_iok", 1, iok[1], !exp_d);
      @(negedge clk); mok[1] = 0; #1;
    end
    iv[1] = 0; dv[1] = 0;

    // Asynchronous reset during BUSY_D.
    @(negedge clk); dv[0] = 1; da[0] = 32'h8000_0040; dw[0] = 0; dsz[0] = 2;
    @(negedge clk); #1;
    chk("r_busy_before", 0, bsy[0], 1'b1);
    #2; resetn = 0; mok[0] = 1; #1;
    chk("r_valid_async", 0, mv[0], 1'b0);
    chk("r_busy_async", 0, bsy[0], 1'b0);
    chk("r_no_dok", 0, dok[0], 1'b0);
    @(negedge clk); mok[0] = 0;
    @(negedge clk); resetn = 1; #1;
    chk("r_lat0_valid", 0, mv[0], 1'b0);
    @(negedge clk); #1;
    chk("r_regrant_valid", 0, mv[0], 1'b1);
    chk("r_regrant_paddr", 0, mpa[0], 32'h0000_0040);
    @(negedge clk); mok[0] = 1; #1;
    chk("r_regrant_dok", 0, dok[0], 1'b1);
    @(negedge clk); dv[0] = 0; mok[0] = 0;

    // Randomized traffic against the model.
    resetn = 0;
    clear_inputs();
    model_reset();
    @(negedge clk); @(negedge clk); resetn = 1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) drive_random(k);
      #1;
      for (int k = 0; k < 2; k++) model_compare(k);
      for (int k = 0; k < 2; k++) model_step(k);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
